// File: rtl/read_slave_if.sv
// Read-address / read-data channel bundle for read_slave.
interface read_slave_if #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1
);
  logic [tagbits-1:0]  ARID;
  logic [BusWidth-1:0] ARADDR;
  logic [3:0]          ARLEN;
  logic [1:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic [1:0]          ARLOCK;
  logic [3:0]          ARCACHE;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;

  logic [tagbits-1:0]  RID;
  logic [BusWidth-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/read_slave.sv
// Single-outstanding burst read slave over a backdoor-loaded word memory.
// Optional READ_SLAVE_DECERR_EN: beats beyond the memory return DECERR instead of aliasing.
module read_slave #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int MemDepth = 64
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  read_slave_if.slave                 bus,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_addr,
  input  logic [BusWidth-1:0]         mem_wdata
);
  localparam int AW = $clog2(MemDepth);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [BusWidth-1:0] mem [MemDepth];
  logic [BusWidth-1:0] addr_q;
  logic [3:0]          len_q;
  logic [3:0]          cnt_q;
  logic [1:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;

  logic [BusWidth-1:0] inc;
  logic [BusWidth-1:0] wrap_mask;
  logic [BusWidth-1:0] next_addr;
  logic [BusWidth-1:0] beat_addr;
  logic [BusWidth-1:0] beat_data;
  logic [1:0]          beat_resp;
  logic                new_err;
  logic                beat_err;
  logic                unused_bits;

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // One lookup path serves both beat 0 (from the AR channel) and later beats.
  always_comb begin
    inc       = BusWidth'(1) << size_q;
    wrap_mask = ((BusWidth'(len_q) + BusWidth'(1)) << size_q) - BusWidth'(1);
    unique case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + inc) & wrap_mask);
      default: next_addr = addr_q + inc;
    endcase

    new_err = (bus.ARBURST == 2'b11)
           || ((bus.ARBURST == 2'b10) && !(bus.ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
           || ((32'd1 << bus.ARSIZE) > 32'(BusWidth / 8));

    beat_addr = (state == IDLE) ? bus.ARADDR : next_addr;
    beat_err  = (state == IDLE) ? new_err : err_q;
    beat_data = mem[beat_addr[AW+1:2]];
    beat_resp = 2'b00;
    if (beat_err) begin
      beat_data = '0;
      beat_resp = 2'b10;
    end
`ifdef READ_SLAVE_DECERR_EN
    else if (beat_addr >= BusWidth'(MemDepth * BusWidth / 8)) begin
      beat_data = '0;
      beat_resp = 2'b11;
    end
`endif
  end

  assign unused_bits = ^{bus.ARLOCK, bus.ARCACHE, bus.ARPROT, beat_addr};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RLAST   <= 1'b0;
      bus.RDATA   <= '0;
      bus.RID     <= '0;
      bus.RRESP   <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ARVALID && bus.ARREADY) begin
            addr_q      <= bus.ARADDR;
            len_q       <= bus.ARLEN;
            size_q      <= bus.ARSIZE;
            burst_q     <= bus.ARBURST;
            err_q       <= new_err;
            cnt_q       <= '0;
            bus.RID     <= bus.ARID;
            bus.RDATA   <= beat_data;
            bus.RRESP   <= beat_resp;
            bus.RLAST   <= (bus.ARLEN == 4'd0);
            bus.RVALID  <= 1'b1;
            bus.ARREADY <= 1'b0;
            state       <= BURST;
          end else begin
            bus.ARREADY <= 1'b1;
          end
        end
        BURST: begin
          if (bus.RREADY) begin
            if (bus.RLAST) begin
              bus.RVALID  <= 1'b0;
              bus.RLAST   <= 1'b0;
              bus.ARREADY <= 1'b1;
              state       <= IDLE;
            end else begin
              addr_q    <= next_addr;
              cnt_q     <= cnt_q + 4'd1;
              bus.RDATA <= beat_data;
              bus.RRESP <= beat_resp;
              bus.RLAST <= ((cnt_q + 4'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_slave.sv
// Directed + randomized checks of read_slave against a burst-level reference model.
module tb_read_slave;
  localparam int BW = 32;
  localparam int TG = 1;
  localparam int MD = 64;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        mem_we = 1'b0;
  logic [5:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] model_mem [MD];
  int rr_pat[$];

  read_slave_if #(.BusWidth(BW), .tagbits(TG)) bus ();

  read_slave #(.BusWidth(BW), .tagbits(TG), .MemDepth(MD)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] size, input logic [1:0] burst);
    longint unsigned inc, w, aa;
    inc = longint'(1) << size;
    w   = (longint'(len) + 1) * inc;
    aa  = longint'(a);
    case (burst)
      2'b00:   return a;
      2'b10:   return 32'((aa - (aa % w)) + ((aa + inc) % w));
      default: return 32'(aa + inc);
    endcase
  endfunction

  function automatic bit is_slverr(input logic [3:0] len, input logic [1:0] size, input logic [1:0] burst);
    return (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
           ((1 << size) > BW / 8);
  endfunction

  task automatic exp_beat(input logic [31:0] a, input bit err, output logic [31:0] d, output logic [1:0] r);
    if (err) begin
      d = '0; r = 2'b10;
    end else begin
`ifdef READ_SLAVE_DECERR_EN
      if (a >= MD * 4) begin
        d = '0; r = 2'b11;
      end else begin
        d = model_mem[(a >> 2) % MD]; r = 2'b00;
      end
`else
      d = model_mem[(a >> 2) % MD]; r = 2'b00;
`endif
    end
  endtask

  task automatic drive_ar(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] size, input logic [1:0] burst);
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARLOCK  = 2'($urandom);
    bus.ARCACHE = 4'($urandom);
    bus.ARPROT  = 3'($urandom);
    bus.ARVALID = 1'b1;
  endtask

  // rmode: 0 RREADY always 1, 1 random, 2 from rr_pat. A backdoor write to wr_idx
  // is issued on the same edge as the handshake of beat wr_beat.
  task automatic do_burst(input string nm, input logic [0:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] size, input logic [1:0] burst,
                          input int rmode, input int wr_beat, input int wr_idx, input logic [31:0] wr_data);
    int guard, b, cyc;
    bit err, rr;
    logic [31:0] ea, ed;
    logic [1:0] er;
    guard = 0;
    while (bus.ARREADY !== 1'b1 && guard < 20) begin
      @(negedge ACLK);
      guard++;
    end
    chk({nm, ":arready_idle"}, bus.ARREADY, 1);
    err = is_slverr(len, size, burst);
    ea = addr;
    exp_beat(ea, err, ed, er);
    drive_ar(id, addr, len, size, burst);
    bus.RREADY = 1'b0;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    b = 0;
    cyc = 0;
    while (b <= int'(len) && cyc < 300) begin
      chk($sformatf("%s:rvalid[%0d]", nm, b), bus.RVALID, 1);
      chk($sformatf("%s:arready_busy[%0d]", nm, b), bus.ARREADY, 0);
      chk($sformatf("%s:rid[%0d]", nm, b), bus.RID, id);
      chk($sformatf("%s:rdata[%0d]", nm, b), bus.RDATA, ed);
      chk($sformatf("%s:rresp[%0d]", nm, b), bus.RRESP, er);
      chk($sformatf("%s:rlast[%0d]", nm, b), bus.RLAST, (b == int'(len)));
      case (rmode)
        0: rr = 1'b1;
        1: rr = ($urandom_range(0, 3) != 0);
        default: rr = (cyc < rr_pat.size()) ? (rr_pat[cyc] != 0) : 1'b1;
      endcase
      bus.RREADY = rr;
      if (rr) begin
        if (b < int'(len)) begin
          ea = step_addr(ea, len, size, burst);
          exp_beat(ea, err, ed, er);
          if (wr_beat == b) begin
            mem_we = 1'b1;
            mem_addr = 6'(wr_idx);
            mem_wdata = wr_data;
            model_mem[wr_idx] = wr_data;
          end
        end
        b++;
      end
      @(negedge ACLK);
      mem_we = 1'b0;
      cyc++;
    end
    if (cyc >= 300) chk({nm, ":burst_timeout"}, cyc, 0);
    bus.RREADY = 1'b0;
    chk({nm, ":rvalid_end"}, bus.RVALID, 0);
    chk({nm, ":rlast_end"}, bus.RLAST, 0);
    chk({nm, ":arready_end"}, bus.ARREADY, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rl;
    logic [1:0]  rs, rb;
    int wb;

    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARLOCK = '0; bus.ARCACHE = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    #12;
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rlast", bus.RLAST, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk("rst_rid", bus.RID, 0);
    chk("rst_rresp", bus.RRESP, 0);

    for (int i = 0; i < MD; i++) begin
      @(negedge ACLK);
      mem_we = 1'b1; mem_addr = 6'(i); mem_wdata = 32'h1000 + 32'(i);
      model_mem[i] = 32'h1000 + 32'(i);
    end
    @(negedge ACLK);
    mem_we = 1'b0;
    chk("rst_arready_hold", bus.ARREADY, 0);
    ARESETn = 1'b1;
    #1 chk("rel_arready_pre_edge", bus.ARREADY, 0);
    @(negedge ACLK);
    chk("rel_arready_post_edge", bus.ARREADY, 1);

    do_burst("incr", 1'b1, 32'h10, 4'd3, 2'd2, 2'b01, 0, -1, 0, 0);
    do_burst("wrap4", 1'b0, 32'h18, 4'd3, 2'd2, 2'b10, 0, -1, 0, 0);
    do_burst("wrap_badlen", 1'b0, 32'h08, 4'd2, 2'd2, 2'b10, 0, -1, 0, 0);
    do_burst("rsvd_burst", 1'b1, 32'h04, 4'd1, 2'd2, 2'b11, 1, -1, 0, 0);
    do_burst("too_wide", 1'b0, 32'h00, 4'd2, 2'd3, 2'b01, 0, -1, 0, 0);
    rr_pat = '{1, 0, 0, 1, 1};
    do_burst("fixed_stall", 1'b0, 32'h20, 4'd2, 2'd2, 2'b00, 2, -1, 0, 0);
    do_burst("edge_fc", 1'b1, 32'hFC, 4'd1, 2'd2, 2'b01, 0, -1, 0, 0);
    do_burst("narrow", 1'b1, 32'h31, 4'd4, 2'd0, 2'b01, 1, -1, 0, 0);
    do_burst("bd_collide", 1'b1, 32'h20, 4'd3, 2'd2, 2'b00, 0, 0, 8, 32'hCAFE0008);

    // Back-to-back ARs with ARVALID held high.
    drive_ar(1'b0, 32'h40, 4'd1, 2'd2, 2'b01);
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    chk("b2b:first_beat0", bus.RDATA, model_mem[16]);
    chk("b2b:first_arready", bus.ARREADY, 0);
    @(negedge ACLK);
    chk("b2b:first_rlast", bus.RLAST, 1);
    chk("b2b:first_beat1", bus.RDATA, model_mem[17]);
    @(negedge ACLK);
    chk("b2b:gap_rvalid", bus.RVALID, 0);
    chk("b2b:gap_arready", bus.ARREADY, 1);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    chk("b2b:second_rvalid", bus.RVALID, 1);
    chk("b2b:second_beat0", bus.RDATA, model_mem[16]);
    chk("b2b:second_arready", bus.ARREADY, 0);
    @(negedge ACLK);
    chk("b2b:second_rlast", bus.RLAST, 1);
    @(negedge ACLK);
    chk("b2b:end_rvalid", bus.RVALID, 0);
    bus.RREADY = 1'b0;

    // Reset pulsed in the middle of a stalled burst.
    drive_ar(1'b1, 32'h00, 4'd7, 2'd2, 2'b01);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    chk("mrst:rvalid_before", bus.RVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("mrst:rvalid_async", bus.RVALID, 0);
    chk("mrst:arready_async", bus.ARREADY, 0);
    chk("mrst:rdata_async", bus.RDATA, 0);
    chk("mrst:rid_async", bus.RID, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mrst:held_rvalid", bus.RVALID, 0);
    ARESETn = 1'b1;
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    chk("mrst:arready_rel", bus.ARREADY, 1);
    chk("mrst:no_more_beats", bus.RVALID, 0);
    bus.RREADY = 1'b0;
    do_burst("post_rst", 1'b0, 32'h2C, 4'd1, 2'd2, 2'b10, 0, -1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int wi;
        wi = $urandom_range(0, MD - 1);
        @(negedge ACLK);
        mem_we = 1'b1; mem_addr = 6'(wi); mem_wdata = $urandom;
        model_mem[wi] = mem_wdata;
        @(negedge ACLK);
        mem_we = 1'b0;
      end
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      rl = 4'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rb = 2'($urandom);
      wb = (rl != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rl) - 1)) : -1;
      do_burst($sformatf("rnd%0d", n), 1'($urandom), ra, rl, rs, rb, 1, wb,
               int'($urandom_range(0, MD - 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/read_slave.md
READ_SLAVE -- requirements
Module: read_slave

Interface
REQ-001 SHALL have parameters: BusWidth, default 32, RDATA/ARADDR width; tagbits, default 1, ID width; MemDepth, default 64, number of BusWidth-bit words in the backing memory (power of 2).
REQ-002 SHALL have these ports, one clock, reset asynchronous active-low:
  ACLK  in  1  clock, all logic on rising edge
  ARESETn  in  1  async active-low reset
  ARID  in  tagbits  read transaction ID
  ARADDR  in  BusWidth  burst start byte address
  ARLEN  in  4  beats minus 1
  ARSIZE  in  2  bytes per beat = 1<<ARSIZE
  ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
  ARLOCK/ARCACHE/ARPROT  in  2/4/3  accepted, ignored
  ARVALID  in  1  address valid;  ARREADY  out  1  slave accepts address
  RID  out  tagbits  echoed ARID;  RDATA  out  BusWidth  read data
  RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
  RLAST  out  1  final beat;  RVALID  out  1  data valid;  RREADY  in  1  master accepts data
  mem_we  in  1  backdoor write strobe;  mem_addr  in  log2(MemDepth)  word index;  mem_wdata  in  BusWidth  write data

Function
REQ-003 SHALL implement FSM states IDLE and BURST; one outstanding transaction.
REQ-004 IDLE: ARREADY=1, RVALID=0; on ARVALID&&ARREADY at edge k, SHALL latch ID/ADDR/LEN/SIZE/BURST, drive ARREADY=0, RVALID=1 with beat 0 registered at edge k, enter BURST.
REQ-005 BURST: RID, RDATA, RRESP, RLAST SHALL hold stable while RVALID&&!RREADY; ARREADY SHALL stay 0.
REQ-006 On RVALID&&RREADY of non-last beat SHALL present next beat in the following cycle with RVALID kept 1 (full throughput, one beat per cycle).
REQ-007 Beats = ARLEN+1; RLAST SHALL be 1 exactly on beat ARLEN (ARLEN=0: beat 0).
REQ-008 On last-beat handshake SHALL drop RVALID/RLAST, return to IDLE, ARREADY=1 the next cycle (one idle cycle between bursts).
REQ-009 RDATA SHALL be memory word at index addr[log2(MemDepth)+1:2] of current beat address; narrow sizes return full word.
REQ-010 Address update per beat: FIXED unchanged; INCR addr+(1<<size) modulo 2^BusWidth; WRAP with boundary W=(ARLEN+1)<<size: addr=(addr&~(W-1))|((addr+(1<<size))&(W-1)).
REQ-011 WRAP with ARLEN not in {1,3,7,15}, ARBURST=11, or (1<<ARSIZE)>BusWidth/8 SHALL return all ARLEN+1 beats with RRESP=SLVERR, RDATA=0.
REQ-012 Otherwise RRESP=OKAY, subject to REQ-017.
REQ-013 Backdoor write SHALL be synchronous on mem_we; a write to the word being registered into RDATA at the same edge SHALL yield old data for that beat, new data thereafter.
REQ-014 ARVALID asserted while in BURST SHALL be ignored until IDLE; no AR is lost if master holds ARVALID.

Reset
REQ-015 While ARESETn=0: ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=00, state IDLE; memory contents not reset.
REQ-016 ARREADY SHALL rise on first ACLK edge after ARESETn deasserts; reset mid-burst SHALL abort burst immediately, no further beats.

Configuration
REQ-017 Macro READ_SLAVE_DECERR_EN: defined -> any beat with address >= MemDepth*BusWidth/8 returns RRESP=DECERR, RDATA=0, burst continues to RLAST; undefined -> address taken modulo memory size, RRESP=OKAY.

Verification
REQ-018 Backdoor mem[i]=0x1000+i; AR ID=1 ADDR=0x10 LEN=3 SIZE=2 INCR, RREADY=1 -> RDATA 0x1004,0x1005,0x1006,0x1007 in 4 consecutive cycles, RID=1, RLAST on 4th, OKAY.
REQ-019 AR ADDR=0x18 LEN=3 SIZE=2 WRAP -> words 6,7,4,5; ADDR=0x08 LEN=2 WRAP -> 3 beats SLVERR, RDATA=0.
REQ-020 FIXED ADDR=0x20 LEN=2, RREADY toggled 1,0,0,1,1 -> 0x1008 three times, outputs stable during stalls, RLAST only on 3rd.
REQ-021 ADDR=0xFC LEN=1 INCR -> with READ_SLAVE_DECERR_EN: beat0 0x103F OKAY, beat1 DECERR/0; without: beat1 0x1000 OKAY.
REQ-022 ARVALID held high for two ARs -> second ARREADY handshake one cycle after first RLAST handshake; ARESETn pulsed low mid-burst -> RVALID=0 asynchronously, ARREADY=1 one edge after release.
